twiddle_sched: RTL and testbench
================================

Name: twiddle_sched

Overview:
- Stage/butterfly scheduler for the multi-point radix-2 DIF FFT.
- Walks all stages and butterflies for a run-time FFT size N = 2^log2n (2..MAX_N).
- Drives the twiddle ROM address (synchronous ROM, 1-cycle read latency, sized for MAX_N) and emits butterfly descriptors (stage, operand indices) aligned with the ROM output data.
- Sits between the FFT top-level control and the butterfly/memory datapath.

Parameters:
- MAX_N, 2048, largest supported FFT size (power of 2); ROM holds MAX_N/2 entries.
- LOG2_MAX, 11, log2(MAX_N).
- IDX_W, 11, width of operand indices and ROM address (= LOG2_MAX).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- log2n  in  4  FFT size exponent; sampled with start; legal 1..LOG2_MAX.
- cfg_err  out  1  one-cycle pulse when start is seen in IDLE with illegal log2n.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last descriptor handshake.
- rom_addr  out  IDX_W  combinational twiddle ROM address.
- bf_valid  out  1  descriptor valid; ROM data_re/data_im is valid in the same cycle.
- bf_ready  in  1  downstream accepts the descriptor.
- bf_stage  out  4  stage s, 0..L-1.
- bf_idx_a  out  IDX_W  upper operand index.
- bf_idx_b  out  IDX_W  lower operand index, = bf_idx_a + half.
- bf_last  out  1  marks the final butterfly of the final stage.

Behaviour:
- Reset (rst_n=0 at an edge): FSM=IDLE, all counters=0, busy=0, done=0, cfg_err=0, bf_valid=0, bf_stage=0, bf_idx_a=0, bf_idx_b=0, bf_last=0. Reset mid-run aborts with no done pulse.
- L = latched log2n. Per stage s: half = N>>(s+1), butterfly counter c = 0..N/2-1.
- j = c & (half-1); g = c >> (L-1-s); bf_idx_a = (g << (L-s)) | j; bf_idx_b = bf_idx_a + half.
- Twiddle index k = j << s; ROM address = k << (LOG2_MAX-L), always < MAX_N/2.
- FSM states: IDLE, RUN, FLUSH.
- IDLE -> RUN: start with 1<=log2n<=LOG2_MAX. Latch L, set stage=0, c=0.
- Illegal log2n with start: cfg_err pulses next cycle and FSM stays in IDLE.
- start outside IDLE is ignored.
- adv = !bf_valid || bf_ready.
- In RUN with adv: output registers load the current (stage, c) descriptor and bf_valid<=1. Then c increments; at c=N/2-1, c wraps to 0 and stage increments.
- The descriptor with stage=L-1 and c=N/2-1 sets bf_last=1, and the FSM goes RUN -> FLUSH.
- In FLUSH with adv: bf_valid<=0, bf_last<=0, FSM -> IDLE, done<=1 for one cycle, busy<=0 on that same edge.
- rom_addr is combinational:
  - If adv and FSM=RUN, it is the address of the current counter descriptor.
  - Otherwise it is the address of the descriptor held in the output registers.
  - This keeps ROM output stable and aligned while stalled.
- Output registers change only when adv=1.
- Throughput: 1 butterfly/cycle with bf_ready held high. Total descriptors = L*N/2.
- Latency: start at edge t0 -> busy=1 after t0; first bf_valid after t0+1.
- bf_ready while bf_valid=0 is don't-care.
- Back-to-back runs: start is accepted in the IDLE cycle right after done.

Test Plan:
- log2n=3 (N=8), bf_ready=1 -> 12 descriptors on consecutive cycles.
  - Stage 0: (0,4,addr0), (1,5,256), (2,6,512), (3,7,768).
  - Stage 1: (0,2,0), (1,3,512), (4,6,0), (5,7,512).
  - Stage 2: pairs (0,1), (2,3), (4,5), (6,7), all addr 0.
  - bf_last only on the 12th descriptor; done one cycle after its handshake.
- log2n=11, bf_ready=1 -> 11264 descriptors.
  - Stage 0, c=1023: (1023,2047), addr 1023.
  - Max rom_addr=1023; busy high for 11264+1 cycles.
- log2n=4 with bf_ready toggling randomly, scoreboarded -> sequence identical to the ready=1 run.
  - While stalled, bf_* and rom_addr are stable, and ROM data_re/data_im match the twiddle for the held descriptor.
- start with log2n=0, then log2n=12 -> cfg_err pulses each time; busy stays 0; no bf_valid.
- log2n=1 -> single descriptor (0,1), addr 0, bf_last=1; done follows.
  - A start issued mid-run is ignored.
- rst_n=0 during stage 2 of N=16 with bf_valid stalled -> all outputs 0 next cycle, no done.
  - A subsequent start with log2n=2 runs cleanly: 4 descriptors.

Source files
------------

// File: rtl/twiddle_sched.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_sched
// Description : Stage/butterfly scheduler for a run-time sized radix-2 DIF
//               FFT. It walks every stage s = 0..L-1 and every butterfly
//               c = 0..N/2-1, drives the synchronous twiddle ROM address, and
//               emits butterfly descriptors that line up with the ROM output.
//
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               start     - begin a transform (sampled only in IDLE)
//               log2n     - FFT size exponent, legal 1..LOG2_MAX
//               cfg_err   - one-cycle pulse for start with illegal log2n
//               busy      - transform in progress
//               done      - one-cycle pulse after the last handshake
//               rom_addr  - combinational twiddle ROM address
//               bf_valid  - descriptor valid (ROM data valid same cycle)
//               bf_ready  - downstream accepts the descriptor
//               bf_stage  - stage of the descriptor
//               bf_idx_a  - upper operand index
//               bf_idx_b  - lower operand index (bf_idx_a + half)
//               bf_last   - final butterfly of the final stage
//
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_sched #(
    parameter int MAX_N    = 2048,
    parameter int LOG2_MAX = 11,
    parameter int IDX_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       log2n,
    output logic             cfg_err,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] rom_addr,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [3:0]       bf_stage,
    output logic [IDX_W-1:0] bf_idx_a,
    output logic [IDX_W-1:0] bf_idx_b,
    output logic             bf_last
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    localparam logic [IDX_W-1:0] c_ONE       = {{(IDX_W-1){1'b0}}, 1'b1};
    // The ROM holds MAX_N/2 entries; masking keeps the address inside it.
    localparam logic [IDX_W-1:0] c_ADDR_MASK = IDX_W'(MAX_N / 2 - 1);
    localparam logic [3:0]       c_LOG2_MAX  = 4'(LOG2_MAX);

    logic [1:0]       r_state;
    logic [1:0]       w_next;

    logic [3:0]       r_len;      // latched L
    logic [3:0]       r_stage;    // current stage counter
    logic [IDX_W-1:0] r_cnt;      // butterfly counter within the stage

    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic             r_cfg_err;
    logic [3:0]       r_bf_stage;
    logic [IDX_W-1:0] r_idx_a;
    logic [IDX_W-1:0] r_idx_b;
    logic [IDX_W-1:0] r_addr;     // ROM address of the held descriptor

    logic             w_adv;
    logic             w_log2n_ok;
    logic [3:0]       w_shr;      // L-1-s = log2(half)
    logic [IDX_W-1:0] w_half;
    logic [IDX_W-1:0] w_j;
    logic [IDX_W-1:0] w_g;
    logic [IDX_W-1:0] w_a;
    logic [IDX_W-1:0] w_b;
    logic [IDX_W-1:0] w_addr;
    logic [IDX_W-1:0] w_cnt_max;
    logic             w_stage_end;
    logic             w_last;

    assign w_adv      = !r_valid || bf_ready;
    assign w_log2n_ok = (log2n != 4'd0) && (log2n <= c_LOG2_MAX);

    // Descriptor for the current (stage, counter) pair. The counter splits
    // into a group number g (upper bits) and an offset j within the group.
    assign w_shr       = r_len - 4'd1 - r_stage;
    assign w_half      = c_ONE << w_shr;
    assign w_j         = r_cnt & (w_half - c_ONE);
    assign w_g         = r_cnt >> w_shr;
    assign w_a         = (w_g << (w_shr + 4'd1)) | w_j;
    assign w_b         = w_a + w_half;
    // Twiddle k = j<<s, scaled up to the MAX_N-sized ROM.
    assign w_addr      = ((w_j << r_stage) << (c_LOG2_MAX - r_len)) & c_ADDR_MASK;
    assign w_cnt_max   = (c_ONE << (r_len - 4'd1)) - c_ONE;
    assign w_stage_end = (r_cnt == w_cnt_max);
    assign w_last      = w_stage_end && (r_stage == r_len - 4'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start && w_log2n_ok) w_next = c_RUN;
            c_RUN:   if (w_adv && w_last)     w_next = c_FLUSH;
            c_FLUSH: if (w_adv)               w_next = c_IDLE;
            default:                          w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state != c_IDLE);
        // When the output registers are about to load, look up the incoming
        // descriptor so ROM data arrives with it; otherwise hold the address
        // of the registered descriptor so stalled data stays aligned.
        if (w_adv && (r_state == c_RUN)) begin
            rom_addr = w_addr;
        end else begin
            rom_addr = r_addr;
        end
    end

    // ------------------------------------------------------------------
    // Counters and descriptor output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len      <= 4'd0;
            r_stage    <= 4'd0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_bf_stage <= 4'd0;
            r_idx_a    <= '0;
            r_idx_b    <= '0;
            r_addr     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_log2n_ok) begin
                            r_len   <= log2n;
                            r_stage <= 4'd0;
                            r_cnt   <= '0;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (w_adv) begin
                        r_valid    <= 1'b1;
                        r_last     <= w_last;
                        r_bf_stage <= r_stage;
                        r_idx_a    <= w_a;
                        r_idx_b    <= w_b;
                        r_addr     <= w_addr;
                        if (w_stage_end) begin
                            r_cnt   <= '0;
                            r_stage <= r_stage + 4'd1;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                c_FLUSH: begin
                    if (w_adv) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_err  = r_cfg_err;
    assign done     = r_done;
    assign bf_valid = r_valid;
    assign bf_last  = r_last;
    assign bf_stage = r_bf_stage;
    assign bf_idx_a = r_idx_a;
    assign bf_idx_b = r_idx_b;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_sched
// Description : Self-checking bench for twiddle_sched. Expected descriptors
//               come from a textbook DIF loop nest (stage / block / offset);
//               a synchronous ROM model checks data alignment with bf_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_sched;

    localparam int MAX_N    = 2048;
    localparam int LOG2_MAX = 11;
    localparam int IDX_W    = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       log2n;
    logic             cfg_err;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] rom_addr;
    logic             bf_valid;
    logic             bf_ready;
    logic [3:0]       bf_stage;
    logic [IDX_W-1:0] bf_idx_a;
    logic [IDX_W-1:0] bf_idx_b;
    logic             bf_last;

    twiddle_sched #(
        .MAX_N    (MAX_N),
        .LOG2_MAX (LOG2_MAX),
        .IDX_W    (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .log2n    (log2n),
        .cfg_err  (cfg_err),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .bf_valid (bf_valid),
        .bf_ready (bf_ready),
        .bf_stage (bf_stage),
        .bf_idx_a (bf_idx_a),
        .bf_idx_b (bf_idx_b),
        .bf_last  (bf_last)
    );

    always #5 clk = ~clk;

    // Synchronous twiddle ROM model with random contents.
    logic [15:0] rom_re_tab [0:MAX_N-1];
    logic [15:0] rom_im_tab [0:MAX_N-1];
    logic [15:0] rom_re;
    logic [15:0] rom_im;
    always @(posedge clk) begin
        rom_re <= rom_re_tab[rom_addr];
        rom_im <= rom_im_tab[rom_addr];
    end

    typedef struct {
        int s;
        int a;
        int b;
        int addr;
    } desc_t;

    desc_t exp_q[$];
    int    n_cmp    = 0;
    int    n_fail   = 0;
    int    max_addr = 0;

    // Reference: classic DIF loops. At stage s blocks span N>>s points; each
    // butterfly pairs offset j with j+span/2, twiddle W_N^(j*2^s).
    task automatic build_model(input int L);
        int n;
        n = 1 << L;
        exp_q.delete();
        for (int s = 0; s < L; s++) begin
            int span;
            int half;
            span = n >> s;
            half = span / 2;
            for (int base = 0; base < n; base += span) begin
                for (int j = 0; j < half; j++) begin
                    desc_t d;
                    d.s    = s;
                    d.a    = base + j;
                    d.b    = base + j + half;
                    d.addr = (j << s) * (MAX_N / n);
                    exp_q.push_back(d);
                end
            end
        end
    endtask

    task automatic drive_run(input int L, input int ready_pct, input bit mid_start,
                             input bit no_wait, output int busy_cnt);
        bit               got_done;
        bit               expect_done;
        desc_t            d;
        logic [IDX_W-1:0] exp_ra;
        build_model(L);
        if (!no_wait) @(negedge clk);
        start    = 1'b1;
        log2n    = 4'(L);
        bf_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || bf_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL run_accept L=%0d: busy=%b valid=%b done=%b, required busy=1 valid=0 done=0",
                     L, busy, bf_valid, done);
        end
        busy_cnt    = 0;
        got_done    = 1'b0;
        expect_done = 1'b0;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            if (expect_done || done === 1'b1) begin
                n_cmp++;
                if (done !== 1'b1 || !expect_done || busy !== 1'b0 || bf_valid !== 1'b0 || bf_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL run_done L=%0d: done=%b busy=%b valid=%b last=%b left=%0d, required done=1 busy=0 valid=0 last=0 left=0",
                             L, done, busy, bf_valid, bf_last, exp_q.size());
                end
                got_done = (done === 1'b1);
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            bf_ready = ($urandom_range(99) < ready_pct);
            if (mid_start) begin
                start = ($urandom_range(3) == 0);
                log2n = 4'($urandom_range(15));
            end
            #1;
            n_cmp++;
            if (cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL run_cfg_err L=%0d: cfg_err=%b, required 0", L, cfg_err);
            end
            if (bf_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL run_extra L=%0d: got (%0d,%0d,%0d), required no descriptor",
                             L, bf_stage, bf_idx_a, bf_idx_b);
                end else begin
                    d = exp_q[0];
                    if (bf_stage !== 4'(d.s) || bf_idx_a !== IDX_W'(d.a) || bf_idx_b !== IDX_W'(d.b) ||
                        bf_last !== (exp_q.size() == 1) ||
                        rom_re !== rom_re_tab[d.addr] || rom_im !== rom_im_tab[d.addr]) begin
                        n_fail++;
                        $display("FAIL run_desc L=%0d: got s=%0d a=%0d b=%0d last=%b re=%h im=%h, required s=%0d a=%0d b=%0d last=%b re=%h im=%h",
                                 L, bf_stage, bf_idx_a, bf_idx_b, bf_last, rom_re, rom_im,
                                 d.s, d.a, d.b, (exp_q.size() == 1),
                                 rom_re_tab[d.addr], rom_im_tab[d.addr]);
                    end
                    exp_ra = (bf_ready && exp_q.size() > 1) ? IDX_W'(exp_q[1].addr) : IDX_W'(d.addr);
                    n_cmp++;
                    if (rom_addr !== exp_ra) begin
                        n_fail++;
                        $display("FAIL run_rom_addr L=%0d: got %0d, required %0d (ready=%b)",
                                 L, rom_addr, exp_ra, bf_ready);
                    end
                    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
                    if (bf_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) expect_done = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got_done && !expect_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout L=%0d: done never seen, %0d descriptors left, required 0",
                     L, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        log2n    = 4'd0;
        bf_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({cfg_err, busy, done, bf_valid, bf_last} !== 5'b0 || bf_stage !== 4'd0 ||
                bf_idx_a !== '0 || bf_idx_b !== '0 || rom_addr !== '0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: err=%b busy=%b done=%b valid=%b last=%b s=%0d a=%0d b=%0d addr=%0d, required all 0",
                         k, cfg_err, busy, done, bf_valid, bf_last, bf_stage, bf_idx_a, bf_idx_b, rom_addr);
            end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_n8();
        int bc;
        drive_run(3, 100, 1'b0, 1'b0, bc);
        n_cmp++;
        if (bc !== 13) begin
            n_fail++;
            $display("FAIL n8_busy_cycles: got %0d, required 13", bc);
        end
    endtask

    task automatic test_n2048();
        int bc;
        max_addr = 0;
        drive_run(11, 100, 1'b0, 1'b0, bc);
        n_cmp++;
        if (bc !== 11265) begin
            n_fail++;
            $display("FAIL n2048_busy_cycles: got %0d, required 11265", bc);
        end
        n_cmp++;
        if (max_addr !== 1023) begin
            n_fail++;
            $display("FAIL n2048_max_addr: got %0d, required 1023", max_addr);
        end
    endtask

    task automatic test_stall();
        int bc;
        drive_run(4, 50, 1'b0, 1'b0, bc);
        drive_run(6, 30, 1'b0, 1'b0, bc);
    endtask

    task automatic test_cfg_err();
        int vals [3];
        vals = '{0, 12, 12 + int'($urandom_range(3))};
        foreach (vals[i]) begin
            @(negedge clk);
            start = 1'b1;
            log2n = 4'(vals[i]);
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || bf_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_pulse log2n=%0d: err=%b busy=%b valid=%b, required err=1 busy=0 valid=0",
                         vals[i], cfg_err, busy, bf_valid);
            end
            @(negedge clk);
            n_cmp++;
            if (cfg_err !== 1'b0 || busy !== 1'b0 || bf_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cfg_err_after log2n=%0d: err=%b busy=%b valid=%b, required all 0",
                         vals[i], cfg_err, busy, bf_valid);
            end
        end
    endtask

    task automatic test_single_mid_start();
        int bc;
        drive_run(1, 100, 1'b1, 1'b0, bc);
        n_cmp++;
        if (bc !== 2) begin
            n_fail++;
            $display("FAIL single_busy_cycles: got %0d, required 2", bc);
        end
        drive_run(5, 70, 1'b1, 1'b0, bc);
    endtask

    task automatic test_reset_mid();
        int bc;
        bit found;
        @(negedge clk);
        start    = 1'b1;
        log2n    = 4'd4;
        bf_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bf_valid === 1'b1 && bf_stage === 4'd2) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_reach: stage 2 never seen, required within 200 cycles");
        end
        bf_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cfg_err, busy, done, bf_valid, bf_last} !== 5'b0 || bf_stage !== 4'd0 ||
            bf_idx_a !== '0 || bf_idx_b !== '0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_state: err=%b busy=%b done=%b valid=%b last=%b s=%0d a=%0d b=%0d addr=%0d, required all 0",
                     cfg_err, busy, done, bf_valid, bf_last, bf_stage, bf_idx_a, bf_idx_b, rom_addr);
        end
        rst_n    = 1'b1;
        bf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || bf_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet[%0d]: done=%b busy=%b valid=%b, required all 0",
                         i, done, busy, bf_valid);
            end
        end
        drive_run(2, 100, 1'b0, 1'b0, bc);
        n_cmp++;
        if (bc !== 5) begin
            n_fail++;
            $display("FAIL reset_mid_rerun_busy: got %0d, required 5", bc);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        drive_run(2, 100, 1'b0, 1'b0, bc);
        drive_run(3, 100, 1'b0, 1'b1, bc);
        n_cmp++;
        if (bc !== 13) begin
            n_fail++;
            $display("FAIL back_to_back_busy: got %0d, required 13", bc);
        end
        drive_run(4, 60, 1'b0, 1'b1, bc);
    endtask

    initial begin
        for (int i = 0; i < MAX_N; i++) begin
            rom_re_tab[i] = 16'($urandom);
            rom_im_tab[i] = 16'($urandom);
        end
        test_reset();
        test_n8();
        test_n2048();
        test_stall();
        test_cfg_err();
        test_single_mid_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
